// File: rtl/mem_return_router.sv
// Memory-side responder for the multiplexed VGA/IO request bus: launches RAM accesses,
// tags reads with their requester and routes returned words back to the right port.
module mem_return_router #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic              vga_sel,
  input  logic              io_sel,
  input  logic              io_we,
  input  logic [DATA_W-1:0] io_wdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_en,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] vga_data,
  output logic              vga_valid,
  output logic [DATA_W-1:0] io_data,
  output logic              io_valid,
  output logic              io_ack,
  output logic [2:0]        rd_pending,
  output logic              conflict_err
);

  // Request strobes carry no backpressure: a single asserted select is a request that
  // is always taken on that edge; both asserted is a protocol error and nothing is taken.
  logic sel_conflict;
  logic rd_acc;
  logic wr_acc;

  assign sel_conflict = vga_sel & io_sel;
  assign wr_acc       = io_sel & ~vga_sel & io_we;
  assign rd_acc       = (vga_sel & ~io_sel) | (io_sel & ~vga_sel & ~io_we);

  logic [ADDR_W-1:0] ram_addr_q,  ram_addr_d;
  logic              ram_en_q,    ram_en_d;
  logic              ram_we_q,    ram_we_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic              io_ack_q,    io_ack_d;
  logic              conflict_q,  conflict_d;

  // Tag pipeline: one entry per RAM latency stage, plus the return-capture slot.
  logic [RD_LAT-1:0] tag_vld_q, tag_vld_d;
  logic [RD_LAT-1:0] tag_vga_q, tag_vga_d;
  logic              ret_vld_q, ret_vld_d;
  logic              ret_vga_q, ret_vga_d;
  logic              tag_out;

  logic [DATA_W-1:0] vga_data_q,  vga_data_d;
  logic              vga_valid_q, vga_valid_d;
  logic [DATA_W-1:0] io_data_q,   io_data_d;
  logic              io_valid_q,  io_valid_d;
  logic [2:0]        pend_q,      pend_d;

  assign tag_out = tag_vld_q[RD_LAT-1];

  always_comb begin
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    ram_en_d    = rd_acc | wr_acc;
    ram_we_d    = wr_acc;
    io_ack_d    = wr_acc;
    conflict_d  = conflict_q | sel_conflict;
    if (rd_acc || wr_acc) begin
      ram_addr_d = addr_in;
    end
    if (wr_acc) begin
      ram_wdata_d = io_wdata;
    end

    tag_vld_d    = tag_vld_q;
    tag_vga_d    = tag_vga_q;
    tag_vld_d[0] = rd_acc;
    tag_vga_d[0] = rd_acc & vga_sel;
    for (int i = 1; i < RD_LAT; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_vga_d[i] = tag_vga_q[i-1];
    end

    // The tag leaving the last stage lines up with ram_rdata one edge later.
    ret_vld_d   = tag_out;
    ret_vga_d   = tag_vga_q[RD_LAT-1];
    vga_valid_d = ret_vld_q & ret_vga_q;
    io_valid_d  = ret_vld_q & ~ret_vga_q;
    vga_data_d  = vga_valid_d ? ram_rdata : vga_data_q;
    io_data_d   = io_valid_d ? ram_rdata : io_data_q;

    pend_d = pend_q + 3'(rd_acc) - 3'(tag_out);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_addr_q  <= '0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_wdata_q <= '0;
      io_ack_q    <= 1'b0;
      conflict_q  <= 1'b0;
      tag_vld_q   <= '0;
      tag_vga_q   <= '0;
      ret_vld_q   <= 1'b0;
      ret_vga_q   <= 1'b0;
      vga_data_q  <= '0;
      vga_valid_q <= 1'b0;
      io_data_q   <= '0;
      io_valid_q  <= 1'b0;
      pend_q      <= '0;
    end else begin
      ram_addr_q  <= ram_addr_d;
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_wdata_q <= ram_wdata_d;
      io_ack_q    <= io_ack_d;
      conflict_q  <= conflict_d;
      tag_vld_q   <= tag_vld_d;
      tag_vga_q   <= tag_vga_d;
      ret_vld_q   <= ret_vld_d;
      ret_vga_q   <= ret_vga_d;
      vga_data_q  <= vga_data_d;
      vga_valid_q <= vga_valid_d;
      io_data_q   <= io_data_d;
      io_valid_q  <= io_valid_d;
      pend_q      <= pend_d;
    end
  end

  assign ram_addr     = ram_addr_q;
  assign ram_en       = ram_en_q;
  assign ram_we       = ram_we_q;
  assign ram_wdata    = ram_wdata_q;
  assign vga_data     = vga_data_q;
  assign vga_valid    = vga_valid_q;
  assign io_data      = io_data_q;
  assign io_valid     = io_valid_q;
  assign io_ack       = io_ack_q;
  assign rd_pending   = pend_q;
  assign conflict_err = conflict_q;

endmodule

// File: tb/tb_mem_return_router.sv
// Bench for mem_return_router: three instances (RD_LAT 1, 2, 4) share one request bus,
// each backed by a registered RAM model of matching latency.
module tb_mem_return_router;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [14:0] addr_in = '0;
  logic        vga_sel = 1'b0;
  logic        io_sel = 1'b0;
  logic        io_we = 1'b0;
  logic [15:0] io_wdata = '0;

  logic [14:0] ram_addr_w   [3];
  logic        ram_en_w     [3];
  logic        ram_we_w     [3];
  logic [15:0] ram_wdata_w  [3];
  logic [15:0] ram_rdata_w  [3];
  logic [15:0] vga_data_w   [3];
  logic        vga_valid_w  [3];
  logic [15:0] io_data_w    [3];
  logic        io_valid_w   [3];
  logic        io_ack_w     [3];
  logic [2:0]  rd_pending_w [3];
  logic        conflict_w   [3];

  logic [15:0] mem [256];

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  // Index 0: RD_LAT=1, index 1: RD_LAT=2 (main instance), index 2: RD_LAT=4.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : (g == 1) ? 2 : 4;
    logic [15:0] rp [4];

    mem_return_router #(.ADDR_W(15), .DATA_W(16), .RD_LAT(LAT)) u_dut (
      .clk          (clk),
      .rst          (rst),
      .addr_in      (addr_in),
      .vga_sel      (vga_sel),
      .io_sel       (io_sel),
      .io_we        (io_we),
      .io_wdata     (io_wdata),
      .ram_addr     (ram_addr_w[g]),
      .ram_en       (ram_en_w[g]),
      .ram_we       (ram_we_w[g]),
      .ram_wdata    (ram_wdata_w[g]),
      .ram_rdata    (ram_rdata_w[g]),
      .vga_data     (vga_data_w[g]),
      .vga_valid    (vga_valid_w[g]),
      .io_data      (io_data_w[g]),
      .io_valid     (io_valid_w[g]),
      .io_ack       (io_ack_w[g]),
      .rd_pending   (rd_pending_w[g]),
      .conflict_err (conflict_w[g])
    );

    always @(posedge clk) begin
      rp[0] <= mem[ram_addr_w[g][7:0]];
      for (int k = 1; k < 4; k++) rp[k] <= rp[k-1];
    end
    assign ram_rdata_w[g] = rp[LAT-1];
  end

  always @(posedge clk) begin
    if (ram_en_w[1] && ram_we_w[1]) mem[ram_addr_w[1][7:0]] <= ram_wdata_w[1];
  end

  typedef struct {
    logic        v;
    logic        i;
    logic        we;
    logic [14:0] a;
    logic [15:0] d;
    logic        exp_en;
    logic        exp_we;
    logic        exp_ack;
    logic [14:0] exp_addr;
    logic [15:0] exp_wdata;
  } vec_t;

  vec_t vecs [6];
  logic [16:0] exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic i, input logic we,
                       input logic [14:0] a, input logic [15:0] d);
    vga_sel  = v;
    io_sel   = i;
    io_we    = we;
    addr_in  = a;
    io_wdata = d;
  endtask

  task automatic idle_n(input int n);
    drive(1'b0, 1'b0, 1'b0, 15'h0, 16'h0);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic wr(input logic [14:0] a, input logic [15:0] d);
    drive(1'b0, 1'b1, 1'b1, a, d);
    tick();
    drive(1'b0, 1'b0, 1'b0, 15'h0, 16'h0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " ram_addr"},   32'(ram_addr_w[1]),   32'h0);
    chk({tag, " ram_en"},     32'(ram_en_w[1]),     32'h0);
    chk({tag, " ram_we"},     32'(ram_we_w[1]),     32'h0);
    chk({tag, " ram_wdata"},  32'(ram_wdata_w[1]),  32'h0);
    chk({tag, " vga_data"},   32'(vga_data_w[1]),   32'h0);
    chk({tag, " vga_valid"},  32'(vga_valid_w[1]),  32'h0);
    chk({tag, " io_data"},    32'(io_data_w[1]),    32'h0);
    chk({tag, " io_valid"},   32'(io_valid_w[1]),   32'h0);
    chk({tag, " io_ack"},     32'(io_ack_w[1]),     32'h0);
    chk({tag, " rd_pending"}, 32'(rd_pending_w[1]), 32'h0);
    chk({tag, " conflict"},   32'(conflict_w[1]),   32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [16:0] got;
    logic        any_v;

    vecs[0] = '{1'b1, 1'b0, 1'b0, 15'h0001, 16'h0000, 1'b1, 1'b0, 1'b0, 15'h0001, 16'hBEEF};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 15'h0002, 16'h1111, 1'b1, 1'b0, 1'b0, 15'h0002, 16'hBEEF};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 15'h0003, 16'h2222, 1'b1, 1'b0, 1'b0, 15'h0003, 16'hBEEF};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 15'h0040, 16'h5A5A, 1'b1, 1'b1, 1'b1, 15'h0040, 16'h5A5A};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 15'h7FFF, 16'h3333, 1'b0, 1'b0, 1'b0, 15'h0040, 16'h5A5A};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 15'h7FFF, 16'h4444, 1'b1, 1'b0, 1'b0, 15'h7FFF, 16'h5A5A};

    // Reset state
    tick();
    tick();
    chk_zero("reset");
    #2 rst = 1'b0;
    tick();

    // Preload through the IO write path
    for (int a = 0; a < 8; a++) wr(15'(a), 16'h1000 + 16'(a));
    wr(15'h00FF, 16'h7777);
    wr(15'h0123, 16'hBEEF);
    idle_n(2);

    // Launch-cycle behaviour, table driven
    for (int n = 0; n < 6; n++) begin
      drive(vecs[n].v, vecs[n].i, vecs[n].we, vecs[n].a, vecs[n].d);
      tick();
      chk($sformatf("vec%0d ram_en", n),    32'(ram_en_w[1]),    32'(vecs[n].exp_en));
      chk($sformatf("vec%0d ram_we", n),    32'(ram_we_w[1]),    32'(vecs[n].exp_we));
      chk($sformatf("vec%0d io_ack", n),    32'(io_ack_w[1]),    32'(vecs[n].exp_ack));
      chk($sformatf("vec%0d ram_addr", n),  32'(ram_addr_w[1]),  32'(vecs[n].exp_addr));
      chk($sformatf("vec%0d ram_wdata", n), 32'(ram_wdata_w[1]), 32'(vecs[n].exp_wdata));
    end
    idle_n(6);
    chk("drain rd_pending", 32'(rd_pending_w[1]), 32'h0);

    // VGA read latency on all three latencies
    drive(1'b1, 1'b0, 1'b0, 15'h0123, 16'h0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 15'h0, 16'h0);
    chk("lat launch ram_en", 32'(ram_en_w[1]), 32'h1);
    chk("lat launch ram_addr", 32'(ram_addr_w[1]), 32'h0123);
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk($sformatf("lat1 vga_valid k%0d", k), 32'(vga_valid_w[0]), 32'(k == 2));
      chk($sformatf("lat2 vga_valid k%0d", k), 32'(vga_valid_w[1]), 32'(k == 3));
      chk($sformatf("lat4 vga_valid k%0d", k), 32'(vga_valid_w[2]), 32'(k == 5));
      chk($sformatf("lat2 io_valid k%0d", k),  32'(io_valid_w[1]),  32'h0);
    end
    for (int g = 0; g < 3; g++) chk($sformatf("lat inst%0d vga_data", g), 32'(vga_data_w[g]), 32'hBEEF);

    // IO write then IO read
    wr(15'h00A5, 16'h00A5);
    chk("iowr io_ack", 32'(io_ack_w[1]), 32'h1);
    chk("iowr ram_we", 32'(ram_we_w[1]), 32'h1);
    chk("iowr ram_wdata", 32'(ram_wdata_w[1]), 32'h00A5);
    chk("iowr io_valid", 32'(io_valid_w[1]), 32'h0);
    idle_n(1);
    chk("iowr ack cleared", 32'(io_ack_w[1]), 32'h0);
    drive(1'b0, 1'b1, 1'b0, 15'h00A5, 16'h0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 15'h0, 16'h0);
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk($sformatf("iord io_valid k%0d", k),  32'(io_valid_w[1]),  32'(k == 3));
      chk($sformatf("iord vga_valid k%0d", k), 32'(vga_valid_w[1]), 32'h0);
    end
    chk("iord io_data", 32'(io_data_w[1]), 32'h00A5);

    // Alternating VGA/IO reads, scoreboarded on the RD_LAT=2 instance
    for (int t = 0; t < 14; t++) begin
      if (t < 8) begin
        drive(t % 2 == 0, t % 2 == 1, 1'b0, 15'(t), 16'h0);
        exp_q.push_back({1'(t % 2 == 0), 16'h1000 + 16'(t)});
      end else begin
        drive(1'b0, 1'b0, 1'b0, 15'h0, 16'h0);
      end
      tick();
      any_v = vga_valid_w[1] | io_valid_w[1];
      chk($sformatf("alt return t%0d", t), 32'(any_v), 32'(t >= 3 && t <= 10));
      chk($sformatf("alt single port t%0d", t), 32'(vga_valid_w[1] & io_valid_w[1]), 32'h0);
      if (t == 4) begin
        chk("alt lat1 rd_pending", 32'(rd_pending_w[0]), 32'h1);
        chk("alt lat2 rd_pending", 32'(rd_pending_w[1]), 32'h2);
        chk("alt lat4 rd_pending", 32'(rd_pending_w[2]), 32'h4);
      end
      if (any_v && exp_q.size() > 0) begin
        got = exp_q.pop_front();
        chk($sformatf("alt port t%0d", t), 32'(vga_valid_w[1]), 32'(got[16]));
        chk($sformatf("alt data t%0d", t),
            32'(vga_valid_w[1] ? vga_data_w[1] : io_data_w[1]), 32'(got[15:0]));
      end
    end
    chk("alt queue empty", 32'(exp_q.size()), 32'h0);

    // Conflicting selects: nothing launched, sticky error until reset
    chk("conflict pre", 32'(conflict_w[1]), 32'h0);
    drive(1'b1, 1'b1, 1'b0, 15'h0010, 16'h0);
    tick();
    chk("conflict ram_en", 32'(ram_en_w[1]), 32'h0);
    chk("conflict set", 32'(conflict_w[1]), 32'h1);
    drive(1'b1, 1'b0, 1'b0, 15'h0001, 16'h0);
    tick();
    idle_n(4);
    chk("conflict sticky", 32'(conflict_w[1]), 32'h1);
    chk("conflict later read", 32'(vga_data_w[1]), 32'h1001);
    #2 rst = 1'b1;
    #1;
    chk("conflict cleared", 32'(conflict_w[1]), 32'h0);
    #2 rst = 1'b0;
    tick();

    // Asynchronous reset with two reads in flight
    wr(15'h0006, 16'h2222);
    drive(1'b1, 1'b0, 1'b0, 15'h0002, 16'h0);
    tick();
    drive(1'b0, 1'b1, 1'b0, 15'h0003, 16'h0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 15'h0, 16'h0);
    chk("inflight rd_pending", 32'(rd_pending_w[1]), 32'h2);
    #2 rst = 1'b1;
    #1;
    chk_zero("async rst");
    chk("async rst lat4 rd_pending", 32'(rd_pending_w[2]), 32'h0);
    @(posedge clk);
    #3 rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      for (int g = 0; g < 3; g++) begin
        chk($sformatf("post rst inst%0d valid k%0d", g, k),
            32'(vga_valid_w[g] | io_valid_w[g]), 32'h0);
      end
    end
    chk("post rst rd_pending", 32'(rd_pending_w[1]), 32'h0);
    chk("post rst vga_data", 32'(vga_data_w[1]), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_return_router.md
Name: mem_return_router

Overview:
Memory-side responder for the time-multiplexed VGA/IO request bus produced by the dispatch arbiter. Per cycle it accepts at most one request (address plus a VGA or IO select strobe) and drives a synchronous single-port RAM. It tags each read with its requester and routes the returned word to the VGA or IO data port with a one-cycle valid pulse. It also performs IO writes and flags protocol violations.

Parameters:
ADDR_W, 15, request/RAM address width
DATA_W, 16, RAM data width
RD_LAT, 2, RAM read latency in cycles; legal range 1..4

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous reset, active-high
addr_in  in  ADDR_W  request address from dispatcher
vga_sel  in  1  VGA read request strobe
io_sel  in  1  IO request strobe
io_we  in  1  with io_sel: 1 = write, 0 = read
io_wdata  in  DATA_W  IO write data
ram_addr  out  ADDR_W  RAM address, registered
ram_en  out  1  RAM access enable, registered
ram_we  out  1  RAM write enable, registered
ram_wdata  out  DATA_W  RAM write data, registered
ram_rdata  in  DATA_W  RAM read data
vga_data  out  DATA_W  last VGA read word, held
vga_valid  out  1  one-cycle pulse: new vga_data
io_data  out  DATA_W  last IO read word, held
io_valid  out  1  one-cycle pulse: new io_data
io_ack  out  1  one-cycle pulse: IO write issued
rd_pending  out  3  reads currently in flight (0..RD_LAT)
conflict_err  out  1  sticky: vga_sel and io_sel both high

Behaviour:
- Reset (async, any time): all outputs 0. Tag pipeline cleared. In-flight reads discarded; their data never reaches vga_data or io_data.
- Accept, sampled at edge E0:
  - Exactly one of vga_sel/io_sel high: request accepted.
  - Both high: nothing accepted, ram_en=0, conflict_err set to 1 until reset.
  - Neither high: idle, ram_en=0.
- io_we is ignored unless io_sel=1.
- Launch: an accepted request drives ram_addr=addr_in and ram_en=1 in the cycle after E0.
  - Read: ram_we=0.
  - Write: ram_we=1, ram_wdata=io_wdata.
  - Idle cycles drive ram_en=0 and ram_we=0. ram_addr and ram_wdata hold their last value.
- RAM contract: ram_rdata is valid during the cycle that begins RD_LAT edges after the launch edge E0.
- Tag pipeline: RD_LAT stages, each holding {valid, is_vga}. A read loads stage 1 at E0 and shifts one stage per edge, with no stalls.
- Return: when the final stage is valid at edge E0+RD_LAT, the block captures ram_rdata into vga_data (is_vga=1) or io_data (is_vga=0) at edge E0+RD_LAT+1.
  - The matching valid output is high for exactly that cycle.
  - Data is held until the next return to the same port.
- Read latency: select sample to valid = RD_LAT+1 edges. With RD_LAT=2, a request at edge 0 gives valid high in the cycle after edge 3.
- Throughput: one request per cycle. Back-to-back reads return in order, one per cycle. VGA and IO returns interleave exactly in request order.
- Write: io_ack is high for the one cycle after E0, concurrent with ram_we. Writes add no tag and never produce io_valid.
- rd_pending: count of valid tag stages. Increments on read accept, decrements on return capture; both in the same cycle leaves it unchanged. It never exceeds RD_LAT.
- Read-after-write to the same address on consecutive cycles: ordering is the RAM's. This block does no forwarding.

Test Plan:
- Reset, then VGA read: vga_sel=1, addr_in=0x0123, RAM word 0xBEEF, RD_LAT=2 → ram_en/ram_addr=0x0123 one cycle after sample; vga_data=0xBEEF with vga_valid pulse 3 edges after sample; io_valid stays 0.
- IO write then IO read: write 0x00A5 → io_ack one cycle after its sample, ram_we=1, ram_wdata=0x00A5. Then read 0x00A5 → io_data=0x00A5 with io_valid; vga_valid stays 0 throughout.
- Alternating VGA/IO reads every cycle, 8 requests, addresses 0..7 preloaded with 0x1000+addr → returns on consecutive cycles in order, each on the correct port; rd_pending steady at 2 mid-stream.
- vga_sel=io_sel=1 for one cycle → ram_en=0 that launch cycle; conflict_err=1 and stays 1 across later traffic until rst pulse clears it.
- Assert rst asynchronously with 2 reads in flight → all outputs 0 immediately; no valid pulse after reset deasserts; rd_pending=0.
- Repeat the first scenario with RD_LAT=1 and RD_LAT=4 → valid at 2 and 5 edges after sample respectively.
